// File: rtl/seq_multiplier.sv
// Shift-and-add unsigned multiplier that borrows an external size-bit adder;
// one partial product per clock, result registered on completion.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; all datapath registers held
// RUN   | one add/shift iteration per edge, cnt counts iterations
// DONE  | product valid and done pulsed for one cycle; back to IDLE next
module seq_multiplier #(
    parameter int size = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [size-1:0]     a,
    input  logic [size-1:0]     b,
    output logic [size-1:0]     add_i1,
    output logic [size-1:0]     add_i2,
    input  logic [size:0]       add_o,
    output logic                busy,
    output logic                done,
    output logic [2*size-1:0]   product
);

    localparam int cnt_w = $clog2(size + 1);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(size - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [size-1:0]  m;
    logic [size-1:0]  q;
    logic [size-1:0]  acc;
    logic [cnt_w-1:0] cnt;

    // {carry, sum, q} shifted right by one; the bit leaving q is discarded
    logic [2*size-1:0] shift_next;
    assign shift_next = {add_o, q[size-1:1]};

    assign add_i1 = acc;
    assign add_i2 = q[0] ? m : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            m       <= '0;
            q       <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= a;
                        q     <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    {acc, q} <= shift_next;
                    if (cnt == cnt_last) begin
                        cnt     <= '0;
                        product <= shift_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: external adder modelled here, every result and
// per-iteration adder operand predicted from plain arithmetic on a and b.
module tb_seq_multiplier;

    localparam int size = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [size-1:0]   a = '0;
    logic [size-1:0]   b = '0;
    logic [size-1:0]   add_i1;
    logic [size-1:0]   add_i2;
    logic [size:0]     add_o;
    logic              busy;
    logic              done;
    logic [2*size-1:0] product;

    int n_checks = 0;
    int n_fail   = 0;
    int last_prod = 0;

    seq_multiplier #(.size(size)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .add_i1  (add_i1),
        .add_i2  (add_i2),
        .add_o   (add_o),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    assign add_o = {1'b0, add_i1} + {1'b0, add_i2};

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge after
    // the DONE->IDLE edge. hold keeps start asserted throughout.
    task automatic mult(input int ma, input int mb, input bit hold);
        int exp_a;
        a = size'(ma);
        b = size'(mb);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int k = 0; k < size; k++) begin
            check("busy_run", int'(busy), 1);
            check("done_run", int'(done), 0);
            check("prod_held_run", int'(product), last_prod);
            check("add_i2", int'(add_i2), ((mb >> k) & 1) ? ma : 0);
            exp_a = (ma * (mb & ((1 << k) - 1))) >> k;
            check("add_i1", int'(add_i1), exp_a);
            a = size'($urandom);
            b = size'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        check("done_pulse", int'(done), 1);
        check("busy_done", int'(busy), 0);
        check("product", int'(product), ma * mb);
        last_prod = ma * mb;
        @(posedge clk);
        @(negedge clk);
        check("done_cleared", int'(done), 0);
        check("busy_idle", int'(busy), 0);
        check("prod_held_idle", int'(product), last_prod);
    endtask

    initial begin
        #3;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_product", int'(product), 0);
        check("rst_add_i1", int'(add_i1), 0);
        check("rst_add_i2", int'(add_i2), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);

        mult(11, 13, 1'b0);
        mult(31, 31, 1'b0);
        mult(0, 17, 1'b0);
        mult(13, 0, 1'b0);

        mult(21, 6, 1'b1);
        check("hold_gap_done", int'(done), 0);
        mult(9, 27, 1'b1);
        start = 1'b0;
        @(negedge clk);

        // Abort 7*9 in its third RUN cycle
        a = 7; b = 9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_abort_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_product", int'(product), 0);
        check("abort_add_i1", int'(add_i1), 0);
        check("abort_add_i2", int'(add_i2), 0);
        last_prod = 0;
        @(posedge clk);
        @(negedge clk);
        check("abort_no_done", int'(done), 0);
        rst = 1'b1;
        @(negedge clk);
        mult(7, 9, 1'b0);

        repeat (20) mult(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'b0);

        for (int ai = 0; ai < 32; ai++)
            for (int bi = 0; bi < 32; bi++)
                mult(ai, bi, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter: size, 5, operand width in bits (legal range 2..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 SHALL have port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port: a  input  size  unsigned multiplicand.
REQ-006 SHALL have port: b  input  size  unsigned multiplier.
REQ-007 SHALL have port: add_i1  output  size  operand 1 to the external size-bit ripple adder.
REQ-008 SHALL have port: add_i2  output  size  operand 2 to the external adder.
REQ-009 SHALL have port: add_o  input  size+1  adder result {carry, sum} returned from the external adder.
REQ-010 SHALL have port: busy  output  1  high while state is RUN.
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: product  output  2*size  registered result of the last completed multiply.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE, with IDLE as the reset state.
REQ-014 SHALL, in IDLE on an edge with start=1: load M<=a, Q<=b, A<=0, cnt<=0, and go to RUN; with start=0, stay in IDLE with all registers held.
REQ-015 SHALL drive add_i1=A and add_i2=(Q[0] ? M : 0) combinationally in every state, with no registering of these outputs.
REQ-016 SHALL, on each RUN edge, shift {add_o[size], add_o[size-1:0], Q} right by one bit into {A, Q} (the bit shifted out of Q is discarded), then increment cnt.
REQ-017 SHALL use a cnt register of width clog2(size+1) bits; the cnt value never exceeds size-1 before it is cleared.
REQ-018 SHALL, on the RUN edge where cnt==size-1, perform the final iteration, load product<={A_next, Q_next}, and go to DONE.
REQ-019 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE on the next edge unconditionally.
REQ-020 SHALL have a latency of size+1 edges from the start-capture edge to the done assertion, giving DONE in cycle size+1 (edge E0 captures, edges E1..E(size) iterate, done high after E(size)).
REQ-021 SHALL ignore start while in RUN or DONE; a request issued there is lost, and a new start requires at least one cycle in IDLE.
REQ-022 SHALL ignore a and b changes after the capture edge; only the values sampled at capture affect the result.
REQ-023 SHALL hold product stable from its load until the next completion, and SHALL NOT change product in IDLE or RUN.
REQ-024 SHALL produce an exact unsigned result in which the adder carry is never lost; the maximum result is (2^size-1)^2, which equals 961 for size=5.
REQ-025 SHALL give product=0 when a=0 or b=0, with the same latency as any other multiply.

Reset
REQ-026 SHALL, while rst=0 and regardless of clock, force: state=IDLE, A=0, Q=0, M=0, cnt=0, product=0, busy=0, done=0, and therefore add_i1=0 and add_i2=0.
REQ-027 SHALL abort any reset asserted mid-RUN or in DONE with no done pulse, leave product=0 afterwards, and accept the first start after rst rises at the first rising edge with start=1.

Verification (size=5, external adder connected)
REQ-028 SHALL cover: a=11, b=13, start pulse at E0 -> busy high E0..E5, done high for one cycle after E5, product=143, then IDLE.
REQ-029 SHALL cover: a=31, b=31 -> product=961 (0x3C1); carry out of every iteration is retained.
REQ-030 SHALL cover: a=0, b=17 and then a=13, b=0 -> product=0 for both, each with done after 6 edges.
REQ-031 SHALL cover: start held high continuously with a/b changed during RUN -> exactly one result for the captured operands; the next multiply begins after one IDLE cycle.
REQ-032 SHALL cover: rst pulled low at the third RUN cycle of 7*9 -> immediate IDLE, product=0, no done; a subsequent 7*9 gives product=63.
REQ-033 SHALL cover: all 1024 (a, b) pairs for size=5, each compared against a*b, with a check that add_i2 equals 0 whenever Q[0]=0.
